// File: rtl/nts_tx_mac_bridge.sv
// nts_tx_mac_bridge: drains engine TX packets into 64-bit MAC beats with zero padding to the minimum frame size
module nts_tx_mac_bridge #(
  parameter int MAC_DATA_WIDTH = 64,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                        i_clk,
  input  logic                        i_areset,
  input  logic                        i_engine_packet_available,
  output logic                        o_engine_packet_read,
  input  logic                        i_engine_fifo_empty,
  output logic                        o_engine_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH-1:0]   i_engine_fifo_rd_data,
  input  logic [3:0]                  i_engine_bytes_last_word,
  output logic                        o_mac_tx_start,
  input  logic                        i_mac_tx_ack,
  output logic [MAC_DATA_WIDTH/8-1:0] o_mac_tx_data_valid,
  output logic [MAC_DATA_WIDTH-1:0]   o_mac_tx_data,
  input  logic                        i_mac_tx_ready,
  output logic                        o_busy,
  output logic [31:0]                 o_frames_sent
);
  typedef enum logic [2:0] {IDLE, START, STREAM, PAD, DONE} state_t;
  localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);
  state_t state, state_nx;
  logic [72:0] sk [2];
  logic [1:0] sk_cnt, base;
  logic pending, last_read, framed, head, beat, pop, wr_idx;
  logic [15:0] bytes, bytes_nx, rem;
  logic [16:0] sum;
  logic [7:0] in_mask;
  logic [63:0] in_data;

  function automatic logic [7:0] top_mask(input logic [15:0] n);
    return n >= 16'd8 ? 8'hFF : ~(8'hFF >> n[3:0]);
  endfunction

  // returned-word masking, beat formation with padding, read gating
  always_comb begin
    in_mask = !i_engine_fifo_empty || i_engine_bytes_last_word == 4'd0 ? 8'hFF : top_mask({12'd0, i_engine_bytes_last_word});
    for (int k = 0; k < 8; k++) in_data[8*k +: 8] = in_mask[k] ? i_engine_fifo_rd_data[8*k +: 8] : 8'd0;
    rem = MIN_B - bytes;
    head = state == STREAM && sk_cnt != 2'd0;
    o_mac_tx_data = head ? sk[0][63:0] : '0;
    o_mac_tx_data_valid = head ? sk[0][71:64] | (sk[0][72] && bytes < MIN_B ? top_mask(rem) : 8'h00) : state == PAD ? top_mask(rem) : 8'h00;
    beat = o_mac_tx_data_valid != 8'h00 && i_mac_tx_ready;
    pop = beat && state == STREAM;
    sum = 17'(bytes) + 17'($countones(o_mac_tx_data_valid));
    bytes_nx = sum[16] ? 16'hFFFF : sum[15:0];
    base = sk_cnt - {1'b0, pop};
    wr_idx = base[0];
    o_engine_fifo_rd_en = state == STREAM && !i_engine_fifo_empty && !last_read && 2'(base + {1'b0, pending}) <= 2'd1;
    o_mac_tx_start = state == START;
    o_engine_packet_read = state == DONE;
    o_busy = state != IDLE;
  end

  // frame sequencing; a last word that reaches the minimum size ends the frame directly
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_engine_packet_available) state_nx = i_engine_fifo_empty ? DONE : START;
      START:   if (i_mac_tx_ack) state_nx = STREAM;
      STREAM:  if (pop && sk[0][72]) state_nx = bytes_nx >= MIN_B ? DONE : PAD;
      PAD:     if (beat && rem <= 16'd8) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // state, occupancy, in-flight read tracking and counters
  always_ff @(posedge i_clk or posedge i_areset)
    if (i_areset) begin
      state <= IDLE;
      sk_cnt <= 2'd0;
      pending <= 1'b0;
      last_read <= 1'b0;
      framed <= 1'b0;
      bytes <= 16'd0;
      o_frames_sent <= 32'd0;
    end else begin
      state <= state_nx;
      sk_cnt <= sk_cnt + {1'b0, pending} - {1'b0, pop};
      pending <= o_engine_fifo_rd_en;
      last_read <= state == START ? 1'b0 : last_read | (pending & i_engine_fifo_empty);
      framed <= state == START || (framed && state != IDLE);
      bytes <= state == START ? 16'd0 : beat ? bytes_nx : bytes;
      o_frames_sent <= o_frames_sent + 32'(state == DONE && framed);
    end

  // two-entry skid storage: shift on pop, returned word lands behind the survivors
  always_ff @(posedge i_clk) begin
    if (pop) sk[0] <= sk[1];
    if (pending) sk[wr_idx] <= {i_engine_fifo_empty, in_mask, in_data};
  end
endmodule
